// File: rtl/game_step_scheduler_if.sv
// game_step_scheduler_if: raster position, game-logic handshake and grid-ownership bundle
interface game_step_scheduler_if #(
  parameter int BIT        = 10,
  parameter int STEP_CNT_W = 8
);
  logic [BIT-1:0]        x_pos;
  logic [BIT-1:0]        y_pos;
  logic [3:0]            speed;
  logic                  pause;
  logic                  step_done;
  logic                  overrun_clr;
  logic                  frame_tick;
  logic                  step_start;
  logic                  game_grant;
  logic                  render_grant;
  logic                  overrun;
  logic [STEP_CNT_W-1:0] step_cnt;
  modport master (
    output x_pos, y_pos, speed, pause, step_done, overrun_clr,
    input  frame_tick, step_start, game_grant, render_grant, overrun, step_cnt
  );
  modport slave (
    input  x_pos, y_pos, speed, pause, step_done, overrun_clr,
    output frame_tick, step_start, game_grant, render_grant, overrun, step_cnt
  );
endinterface

// File: rtl/game_step_scheduler.sv
// game_step_scheduler: paces game steps per frame and grants grid memory to game logic during vblank
module game_step_scheduler #(
  parameter int BIT        = 10,
  parameter int HRES       = 640,
  parameter int VRES       = 480,
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int STEP_CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  game_step_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
  if (HRES >= H_TOTAL || VRES >= V_TOTAL) begin : g_bad_geom
    $error("visible area must be smaller than the total raster");
  end
  state_t                state_q, state_d;
  logic [3:0]            frame_cnt_q, frame_cnt_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  step_start_q, step_start_d;
  logic                  game_grant_q, game_grant_d;
  logic                  overrun_q, overrun_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic                  vs, we, due;
  logic [3:0]            spd;
  assign vs  = bus.x_pos == BIT'(0) && bus.y_pos == BIT'(VRES);
  assign we  = bus.x_pos == BIT'(H_TOTAL - 1) && bus.y_pos == BIT'(V_TOTAL - 1);
  assign spd = (bus.speed == 4'd0) ? 4'd1 : bus.speed;
  // >= rather than == so a speed reduction never strands frame_cnt above the new period
  assign due = frame_cnt_q >= spd - 4'd1;
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    frame_tick_d = vs;
    step_start_d = 1'b0;
    game_grant_d = game_grant_q;
    overrun_d    = overrun_q & ~bus.overrun_clr;
    step_cnt_d   = step_cnt_q;
    case (state_q)
      IDLE: if (vs && !bus.pause) begin
        frame_cnt_d  = due ? 4'd0 : frame_cnt_q + 4'd1;
        step_start_d = due;
        game_grant_d = due;
        state_d      = due ? RUN : IDLE;
      end
      RUN: if (bus.step_done) begin
        game_grant_d = 1'b0;
        step_cnt_d   = step_cnt_q + 1'b1;
        state_d      = IDLE;
      end else if (we) begin
        game_grant_d = 1'b0;
        overrun_d    = 1'b1;
        state_d      = STALL;
      end
      STALL: if (vs) begin
        game_grant_d = 1'b1;
        state_d      = RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      frame_tick_q <= 1'b0;
      step_start_q <= 1'b0;
      game_grant_q <= 1'b0;
      overrun_q    <= 1'b0;
      step_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_tick_q <= frame_tick_d;
      step_start_q <= step_start_d;
      game_grant_q <= game_grant_d;
      overrun_q    <= overrun_d;
      step_cnt_q   <= step_cnt_d;
    end
  end
  assign bus.frame_tick   = frame_tick_q;
  assign bus.step_start   = step_start_q;
  assign bus.game_grant   = game_grant_q;
  assign bus.render_grant = ~game_grant_q;
  assign bus.overrun      = overrun_q;
  assign bus.step_cnt     = step_cnt_q;
endmodule

// File: tb/tb_game_step_scheduler.sv
// tb_game_step_scheduler: directed raster events with a cycle-stamped scoreboard of output changes
module tb_game_step_scheduler;
  typedef struct {
    int          cyc;
    logic [12:0] v;
  } exp_t;
  logic clk = 1'b1;
  logic rst_n = 1'b0;
  logic rst_v = 1'b0;
  logic pause_v = 1'b0;
  logic [3:0] speed_v = 4'd3;
  logic e_gg = 1'b0, e_ov = 1'b0;
  logic [7:0] e_sc = 8'd0;
  logic [12:0] last_v = '0;
  bit have_last = 0;
  int t = 0;
  int total = 0, passed = 0;
  exp_t exp_q[$];
  game_step_scheduler_if #(.BIT(10), .STEP_CNT_W(8)) bus();
  game_step_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic void note(input logic ft, input logic ss);
    logic [12:0] v;
    v = {ft, ss, e_gg, ~e_gg, e_ov, e_sc};
    if (!have_last || v != last_v) exp_q.push_back('{cyc: t, v: v});
    last_v = v;
    have_last = 1;
  endfunction
  task automatic cyc(input int x, input int y, input logic d, input logic c,
                     input logic ft, input logic ss, input logic gg, input logic ov,
                     input logic [7:0] sc);
    @(negedge clk);
    rst_n = rst_v;
    bus.speed = speed_v;
    bus.pause = pause_v;
    bus.x_pos = 10'(x);
    bus.y_pos = 10'(y);
    bus.step_done = d;
    bus.overrun_clr = c;
    @(posedge clk);
    t++;
    e_gg = gg;
    e_ov = ov;
    e_sc = sc;
    note(ft, ss);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(5, 5, 0, 0, 0, 0, e_gg, e_ov, e_sc);
  endtask
  task automatic vs(input logic ss, input logic gg);
    cyc(0, 480, 0, 0, 1, ss, gg, e_ov, e_sc);
  endtask
  task automatic done_now(input logic [7:0] sc);
    cyc(5, 5, 1, 0, 0, 0, 0, e_ov, sc);
  endtask
  task automatic we(input logic d, input logic c, input logic gg, input logic ov,
                    input logic [7:0] sc);
    cyc(799, 524, d, c, 0, 0, gg, ov, sc);
    cyc(0, 0, 0, 0, 0, 0, e_gg, e_ov, e_sc);
  endtask
  task automatic we_i();
    we(0, 0, e_gg, e_ov, e_sc);
  endtask
  task automatic chk(input string name, input int n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s at cycle %0d: got %h, want %h", name, n, got, want);
  endtask
  // Monitor: any change on the outputs must match the next queued expectation, including its cycle
  initial begin
    int n;
    logic [12:0] cur, prev;
    bit first;
    exp_t e;
    n = 0;
    first = 1;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {bus.frame_tick, bus.step_start, bus.game_grant, bus.render_grant, bus.overrun, bus.step_cnt};
      if (n > 0 && (first || cur !== prev)) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_change at cycle %0d: got %h, want no change", n, cur);
        end else begin
          e = exp_q.pop_front();
          chk("change_cycle", n, n, e.cyc);
          chk("outputs{ft,ss,gg,rg,ov,cnt}", n, 32'(cur), 32'(e.v));
        end
        first = 0;
      end
      prev = cur;
      n++;
    end
  end
  initial begin
    bus.x_pos = '0;
    bus.y_pos = '0;
    bus.speed = 4'd3;
    bus.pause = 1'b0;
    bus.step_done = 1'b0;
    bus.overrun_clr = 1'b0;
    idle(2);
    rst_v = 1'b1;
    // speed 3: steps on frames 3 and 6
    idle(2); vs(0, 0); idle(2); we_i();
    idle(2); vs(0, 0); idle(2); we_i();
    idle(2); vs(1, 1); idle(2); done_now(1); we_i();
    idle(2); vs(0, 0); idle(2); we_i();
    idle(2); vs(0, 0); idle(2); we_i();
    idle(2); vs(1, 1); idle(2); done_now(2); we_i();
    idle(2); vs(0, 0); idle(2); we_i();
    // speed 1 with frame_cnt already past spd-1; grant held exactly 100 cycles
    speed_v = 4'd1;
    idle(2); vs(1, 1); idle(99); done_now(3); we_i();
    // overrun, resume in next blanking (pause ignored), set beats clear, then clear
    idle(2); vs(1, 1); idle(5); we(0, 0, 0, 1, 3);
    idle(2); pause_v = 1'b1; vs(0, 1); pause_v = 1'b0; idle(3); we(0, 1, 0, 1, 3);
    idle(2); vs(0, 1); idle(3); done_now(4); idle(1);
    cyc(5, 5, 0, 1, 0, 0, 0, 0, 4);
    // step_done coincident with window end: done wins
    idle(2); vs(1, 1); idle(4); we(1, 0, 0, 0, 5);
    // speed 0 acts as 1
    speed_v = 4'd0;
    idle(2); vs(1, 1); done_now(6); we_i();
    idle(2); vs(1, 1); done_now(7); we_i();
    // pause freezes frame_cnt: with speed 2 the first frame after must not step
    pause_v = 1'b1;
    repeat (4) begin idle(2); vs(0, 0); we_i(); end
    pause_v = 1'b0;
    speed_v = 4'd2;
    idle(2); vs(0, 0); we_i();
    idle(2); vs(1, 1); done_now(8); we_i();
    // reset mid-RUN, then scheduling restarts after 2 frames
    idle(2); vs(0, 0); we_i();
    idle(2); vs(1, 1); idle(5);
    rst_v = 1'b0;
    cyc(5, 5, 0, 0, 0, 0, 0, 0, 0);
    rst_v = 1'b1;
    idle(2); vs(0, 0); we_i();
    idle(2); vs(1, 1); done_now(1); we_i();
    idle(3);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL missing_changes: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
